snake_move_scheduler: RTL and testbench

- Paces snake motion during PLAY: issues one move request per game tick to the snake body datapath.
- Latches player direction from the four key pulses, rejecting 180° reversals.
- Carries a one-shot grow flag after food is eaten.
- Raises speed (shorter tick period) every FOODS_PER_LEVEL foods. Sits between game_status_control / key debouncers and the body-shift datapath.

---
 rtl/snake_move_scheduler.sv | 177 +++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Paces snake moves during PLAY: one move request per game tick, latched
// non-reversing direction, one-shot grow flag and food-driven speed levels.
module snake_move_scheduler #(
   parameter int unsigned BASE_PERIOD     = 32'd12_500_000,
   parameter int unsigned STEP_PERIOD     = 32'd1_250_000,
   parameter int unsigned MIN_PERIOD      = 32'd2_500_000,
   parameter int unsigned FOODS_PER_LEVEL = 32'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic       restart,
   input  logic       key1_press,
   input  logic       key2_press,
   input  logic       key3_press,
   input  logic       key4_press,
   input  logic       eat_food,
   input  logic       move_ack,
   output logic       move_req,
   output logic [1:0] dir,
   output logic       grow,
   output logic [3:0] speed_level
);

   localparam int unsigned LVL_MAX = (BASE_PERIOD - MIN_PERIOD) / STEP_PERIOD;
   localparam int unsigned FOOD_W  = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
   localparam int unsigned TICK_W  = 32;

   localparam logic [1:0] GS_START = 2'b01;
   localparam logic [1:0] GS_PLAY  = 2'b10;
   localparam logic [1:0] GS_DIE   = 2'b11;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic {ST_WAIT, ST_REQ} state_e;

   state_e              state_q, state_d;
   logic                move_req_q, move_req_d;
   logic [1:0]          dir_q, dir_d;
   logic                grow_q, grow_d;
   logic [3:0]          lvl_q, lvl_d;
   logic [1:0]          pend_dir_q, pend_dir_d;
   logic                grow_pend_q, grow_pend_d;
   logic [FOOD_W-1:0]   food_cnt_q, food_cnt_d;
   logic [TICK_W-1:0]   tick_q, tick_d;

   logic                play_c;
   logic                keys_live_c;
   logic                eat_live_c;
   logic                key_any_c;
   logic [1:0]          key_dir_c;
   logic                reversal_c;
   logic [TICK_W-1:0]   period_c;

   assign play_c      = (game_status == GS_PLAY);
   assign keys_live_c = (game_status == GS_START) || (game_status == GS_PLAY);
   assign eat_live_c  = eat_food && (game_status != GS_DIE);
   assign key_any_c   = key1_press | key2_press | key3_press | key4_press;

   // Priority encode the keys: only the winning key is ever considered.
   always_comb begin
      key_dir_c = DIR_RIGHT;
      if (key1_press)      key_dir_c = DIR_UP;
      else if (key2_press) key_dir_c = DIR_DOWN;
      else if (key3_press) key_dir_c = DIR_LEFT;
   end

   // Same axis, opposite sense: checked against the committed direction.
   assign reversal_c = (key_dir_c[1] == dir_q[1]) && (key_dir_c[0] != dir_q[0]);

   assign period_c = TICK_W'(BASE_PERIOD) - TICK_W'(lvl_q) * TICK_W'(STEP_PERIOD);

   always_comb begin
      state_d     = state_q;
      move_req_d  = move_req_q;
      dir_d       = dir_q;
      grow_d      = grow_q;
      lvl_d       = lvl_q;
      pend_dir_d  = pend_dir_q;
      grow_pend_d = grow_pend_q;
      food_cnt_d  = food_cnt_q;
      tick_d      = tick_q;

      if (restart) begin
         state_d     = ST_WAIT;
         move_req_d  = 1'b0;
         dir_d       = DIR_RIGHT;
         grow_d      = 1'b0;
         lvl_d       = 4'd0;
         pend_dir_d  = DIR_RIGHT;
         grow_pend_d = 1'b0;
         food_cnt_d  = '0;
         tick_d      = '0;
      end else begin
         if (keys_live_c && key_any_c && !reversal_c) begin
            pend_dir_d = key_dir_c;
         end

         if (eat_live_c) begin
            grow_pend_d = 1'b1;
            if (food_cnt_q == FOOD_W'(FOODS_PER_LEVEL - 1)) begin
               food_cnt_d = '0;
               if (lvl_q != 4'(LVL_MAX)) begin
                  lvl_d = lvl_q + 4'd1;
               end
            end else begin
               food_cnt_d = food_cnt_q + FOOD_W'(1);
            end
         end

         case (state_q)
            ST_WAIT: begin
               // >= so a level-up that shortens the period below the
               // running count fires on the very next cycle.
               if (play_c) begin
                  if (tick_q >= period_c - TICK_W'(1)) begin
                     move_req_d = 1'b1;
                     dir_d      = pend_dir_q;
                     grow_d     = grow_pend_q;
                     tick_d     = '0;
                     state_d    = ST_REQ;
                  end else begin
                     tick_d = tick_q + TICK_W'(1);
                  end
               end
            end
            ST_REQ: begin
               // A food pulse in the ack cycle belongs to the next move.
               if (move_ack) begin
                  move_req_d  = 1'b0;
                  grow_d      = 1'b0;
                  grow_pend_d = eat_live_c;
                  state_d     = ST_WAIT;
               end else if (!play_c) begin
                  move_req_d = 1'b0;
                  grow_d     = 1'b0;
                  state_d    = ST_WAIT;
               end
            end
            default: state_d = ST_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_WAIT;
         move_req_q  <= 1'b0;
         dir_q       <= DIR_RIGHT;
         grow_q      <= 1'b0;
         lvl_q       <= 4'd0;
         pend_dir_q  <= DIR_RIGHT;
         grow_pend_q <= 1'b0;
         food_cnt_q  <= '0;
         tick_q      <= '0;
      end else begin
         state_q     <= state_d;
         move_req_q  <= move_req_d;
         dir_q       <= dir_d;
         grow_q      <= grow_d;
         lvl_q       <= lvl_d;
         pend_dir_q  <= pend_dir_d;
         grow_pend_q <= grow_pend_d;
         food_cnt_q  <= food_cnt_d;
         tick_q      <= tick_d;
      end
   end

   assign move_req    = move_req_q;
   assign dir         = dir_q;
   assign grow        = grow_q;
   assign speed_level = lvl_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Scoreboard bench for snake_move_scheduler: expected moves (dir, grow,
// interval) are queued by the stimulus and popped on each move_req rise.
module tb_snake_move_scheduler;

   localparam int unsigned BASE  = 20;
   localparam int unsigned STEP  = 4;
   localparam int unsigned MINP  = 8;
   localparam int unsigned FOODS = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_status;
   logic       restart;
   logic       key1_press, key2_press, key3_press, key4_press;
   logic       eat_food;
   logic       move_ack;
   logic       move_req;
   logic [1:0] dir;
   logic       grow;
   logic [3:0] speed_level;

   snake_move_scheduler #(
      .BASE_PERIOD    (BASE),
      .STEP_PERIOD    (STEP),
      .MIN_PERIOD     (MINP),
      .FOODS_PER_LEVEL(FOODS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .game_status(game_status),
      .restart    (restart),
      .key1_press (key1_press),
      .key2_press (key2_press),
      .key3_press (key3_press),
      .key4_press (key4_press),
      .eat_food   (eat_food),
      .move_ack   (move_ack),
      .move_req   (move_req),
      .dir        (dir),
      .grow       (grow),
      .speed_level(speed_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [1:0] dir;
      logic       grow;
      int         iv;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_cnt = 0;
   int   ref_cyc = 0;
   bit   ack_en  = 1'b0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_cnt);
      end
   endtask

   task automatic expect_move(input int id, input logic [1:0] d, input logic g, input int iv);
      exp_t e;
      e.id = id; e.dir = d; e.grow = g; e.iv = iv;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // keys bit0..3 = key1..key4; one-cycle pulse
   task automatic pulse(input logic [3:0] keys, input logic eat);
      {key4_press, key3_press, key2_press, key1_press} = keys;
      eat_food = eat;
      @(negedge clk);
      {key4_press, key3_press, key2_press, key1_press} = 4'b0000;
      eat_food = 1'b0;
   endtask

   task automatic wait_rise();
      int b;
      b = 0;
      while (move_req && b < 200) begin @(negedge clk); b++; end
      while (!move_req && b < 200) begin @(negedge clk); b++; end
      if (!move_req) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_move: timed out with move_req=%0d, required 1", move_req);
      end
   endtask

   // Datapath model: acknowledges one cycle after it sees move_req.
   initial begin
      logic mreq_prev;
      mreq_prev = 1'b0;
      move_ack  = 1'b0;
      forever begin
         @(negedge clk);
         move_ack  = ack_en && mreq_prev;
         mreq_prev = move_req;
      end
   end

   // Monitor: pops one expected move per move_req rising edge.
   initial begin
      logic prev;
      exp_t e;
      int   iv;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (move_req && !prev) begin
            iv      = cyc_cnt - ref_cyc;
            ref_cyc = cyc_cnt;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_move: move_req rose at cycle %0d, required none", cyc_cnt);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("move%0d_dir", e.id), int'(dir), int'(e.dir));
               check($sformatf("move%0d_grow", e.id), int'(grow), int'(e.grow));
               if (e.iv > 0) check($sformatf("move%0d_interval", e.id), iv, e.iv);
            end
         end
         prev = move_req;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; restart = 1'b0; game_status = 2'b00; eat_food = 1'b0;
      {key4_press, key3_press, key2_press, key1_press} = 4'b0000;
      tick(3);
      check("reset_move_req", int'(move_req), 0);
      check("reset_dir", int'(dir), 3);
      check("reset_grow", int'(grow), 0);
      check("reset_speed", int'(speed_level), 0);
      rst = 1'b1;
      tick(2);
      restart = 1'b1; tick(2); restart = 1'b0;
      game_status = 2'b01; tick(3);

      ack_en = 1'b1;
      expect_move(1, 2'b11, 1'b0, 20);
      game_status = 2'b10; ref_cyc = cyc_cnt;
      wait_rise();                                   // M1
      expect_move(2, 2'b11, 1'b0, 22);
      tick(5); pulse(4'b0100, 1'b0);                 // left vs right: rejected
      wait_rise();                                   // M2
      expect_move(3, 2'b01, 1'b0, 22);
      tick(4); pulse(4'b0001, 1'b0); tick(2); pulse(4'b0010, 1'b0);
      wait_rise();                                   // M3
      expect_move(4, 2'b01, 1'b0, 22);
      tick(5); pulse(4'b1001, 1'b0);                 // up wins, then rejected vs down
      wait_rise();                                   // M4
      expect_move(5, 2'b10, 1'b1, 22);
      tick(5); pulse(4'b1100, 1'b0); tick(2); pulse(4'b0000, 1'b1);
      wait_rise();                                   // M5
      expect_move(6, 2'b10, 1'b1, 18);
      tick(1); pulse(4'b0000, 1'b1);                 // eat in the ack cycle
      tick(1);
      check("speed_after_2_eats", int'(speed_level), 1);
      wait_rise();                                   // M6
      expect_move(7, 2'b10, 1'b0, 18);
      wait_rise();                                   // M7
      expect_move(8, 2'b10, 1'b1, 14);
      tick(4); pulse(4'b0000, 1'b1); tick(1); pulse(4'b0000, 1'b1);
      check("speed_after_4_eats", int'(speed_level), 2);
      wait_rise();                                   // M8
      expect_move(9, 2'b10, 1'b0, 14);
      wait_rise();                                   // M9
      expect_move(10, 2'b10, 1'b1, 11);              // count already past new period-1
      tick(7); pulse(4'b0000, 1'b1); tick(1); pulse(4'b0000, 1'b1);
      check("speed_after_6_eats", int'(speed_level), 3);
      wait_rise();                                   // M10
      expect_move(11, 2'b10, 1'b0, 10);
      wait_rise();                                   // M11
      expect_move(12, 2'b10, 1'b1, 10);
      tick(3); pulse(4'b0000, 1'b1); tick(1); pulse(4'b0000, 1'b1);
      check("speed_saturated", int'(speed_level), 3);
      wait_rise();                                   // M12
      expect_move(13, 2'b10, 1'b0, 10);
      wait_rise();                                   // M13

      ack_en = 1'b0;
      tick(1); game_status = 2'b11;
      tick(1);
      check("die_drops_move_req", int'(move_req), 0);
      pulse(4'b0001, 1'b1); tick(2); pulse(4'b0001, 1'b1);
      tick(30);
      check("die_no_request", int'(move_req), 0);
      check("die_dir_kept", int'(dir), 2);
      check("die_speed_kept", int'(speed_level), 3);

      expect_move(14, 2'b10, 1'b0, 8);
      ack_en = 1'b1; game_status = 2'b10; ref_cyc = cyc_cnt;
      wait_rise();                                   // M14
      ack_en = 1'b0;
      tick(1);
      rst = 1'b0;
      #1;
      check("async_rst_move_req", int'(move_req), 0);
      check("async_rst_dir", int'(dir), 3);
      check("async_rst_grow", int'(grow), 0);
      check("async_rst_speed", int'(speed_level), 0);
      @(negedge clk);
      expect_move(15, 2'b11, 1'b0, 20);
      rst = 1'b1; ack_en = 1'b1; ref_cyc = cyc_cnt;
      wait_rise();                                   // M15

      tick(4);
      restart = 1'b1; key1_press = 1'b1;
      tick(1); key1_press = 1'b0; eat_food = 1'b1;
      tick(1); eat_food = 1'b0;
      tick(4);
      restart = 1'b0; ref_cyc = cyc_cnt;
      check("restart_move_req", int'(move_req), 0);
      check("restart_dir", int'(dir), 3);
      check("restart_grow", int'(grow), 0);
      check("restart_speed", int'(speed_level), 0);
      expect_move(16, 2'b11, 1'b0, 20);
      wait_rise();                                   // M16
      tick(4); pulse(4'b0000, 1'b1); tick(2);
      check("restart_food_cleared", int'(speed_level), 0);
      check("scoreboard_drained", exp_q.size(), 0);
      tick(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
